// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the run_ctrl execution sequencer.
// Imported by the handshake interface and the sequencer itself.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HOST = 3'd1,
      RST  = 3'd2,
      RUN  = 3'd3,
      FIN  = 3'd4
   } run_state_t;

   localparam int unsigned RUN_CTRL_CW      = 16;
   localparam int unsigned RUN_CTRL_RST_CYC = 2;
   localparam int unsigned RUN_CTRL_MAX_CYC = 1000;

endpackage

// File: rtl/run_ctrl_if.sv
// Harness/core handshake bundle around run_ctrl.
// The master side is the test harness, the slave side is the sequencer.
interface run_ctrl_if
   import run_ctrl_pkg::*;
#(
   parameter int unsigned CW = RUN_CTRL_CW
);
   logic          req;
   logic          halt;
   logic          host_req;
   logic          cpu_reset;
   logic          cpu_run;
   logic          host_gnt;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycle_cnt;

   modport master (
      output req, halt, host_req,
      input  cpu_reset, cpu_run, host_gnt, busy, done, timeout, cycle_cnt
   );

   modport slave (
      input  req, halt, host_req,
      output cpu_reset, cpu_run, host_gnt, busy, done, timeout, cycle_cnt
   );
endinterface

// File: rtl/run_ctrl.sv
// Execution sequencer: holds the core in reset, runs it until Halt or the
// cycle budget expires, and hands dat_mem to the host while the core is stopped.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned CW      = RUN_CTRL_CW,
   parameter int unsigned RST_CYC = RUN_CTRL_RST_CYC,
   parameter int unsigned MAX_CYC = RUN_CTRL_MAX_CYC
) (
   input  logic     clk,
   input  logic     reset,
   run_ctrl_if.slave bus
);

   localparam int unsigned RW = $clog2(RST_CYC + 1);

   run_state_t    state_r,      state_next_s;
   logic [RW-1:0] rst_cnt_r,    rst_cnt_next_s;
   logic [CW-1:0] cycle_cnt_r,  cycle_cnt_next_s;
   logic          done_r,       done_next_s;
   logic          timeout_r,    timeout_next_s;
   logic          cpu_reset_r,  cpu_reset_next_s;
   logic          cpu_run_r,    cpu_run_next_s;
   logic          busy_r,       busy_next_s;
   logic          host_gnt_r,   host_gnt_next_s;

   // Next-state and next-output decode from registered state and inputs
   always_comb begin
      state_next_s     = state_r;
      rst_cnt_next_s   = rst_cnt_r;
      cycle_cnt_next_s = cycle_cnt_r;
      done_next_s      = done_r;
      timeout_next_s   = timeout_r;
      case (state_r)
         IDLE: begin
            if (bus.host_req) begin
               state_next_s = HOST;
            end else if (bus.req) begin
               state_next_s     = RST;
               rst_cnt_next_s   = RW'(RST_CYC - 1);
               cycle_cnt_next_s = {CW{1'b0}};
               timeout_next_s   = 1'b0;
            end else begin
               state_next_s = IDLE;
            end
         end
         HOST: begin
            if (bus.host_req) begin
               state_next_s = HOST;
            end else begin
               state_next_s = IDLE;
            end
         end
         RST: begin
            if (rst_cnt_r == {RW{1'b0}}) begin
               state_next_s = RUN;
            end else begin
               rst_cnt_next_s = rst_cnt_r - {{(RW-1){1'b0}}, 1'b1};
            end
         end
         RUN: begin
            // The exiting edge is counted too, so a timeout lands on MAX_CYC exactly
            cycle_cnt_next_s = cycle_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (bus.halt) begin
               state_next_s   = FIN;
               done_next_s    = 1'b1;
               timeout_next_s = 1'b0;
            end else if (cycle_cnt_r == CW'(MAX_CYC - 1)) begin
               state_next_s   = FIN;
               done_next_s    = 1'b1;
               timeout_next_s = 1'b1;
            end else begin
               state_next_s = RUN;
            end
         end
         FIN: begin
            if (!bus.req && !bus.host_req) begin
               state_next_s   = IDLE;
               done_next_s    = 1'b0;
               timeout_next_s = 1'b0;
            end else begin
               state_next_s = FIN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase

      cpu_reset_next_s = (state_next_s == IDLE) || (state_next_s == HOST) ||
                         (state_next_s == RST);
      cpu_run_next_s   = (state_next_s == RUN);
      busy_next_s      = (state_next_s == RST) || (state_next_s == RUN);
      // Readback grant in FIN only once FIN is established, never on the halting edge
      host_gnt_next_s  = (state_next_s == HOST) ||
                         ((state_r == FIN) && (state_next_s == FIN) && bus.host_req);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         rst_cnt_r   <= {RW{1'b0}};
         cycle_cnt_r <= {CW{1'b0}};
         done_r      <= 1'b0;
         timeout_r   <= 1'b0;
         cpu_reset_r <= 1'b1;
         cpu_run_r   <= 1'b0;
         busy_r      <= 1'b0;
         host_gnt_r  <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         rst_cnt_r   <= rst_cnt_next_s;
         cycle_cnt_r <= cycle_cnt_next_s;
         done_r      <= done_next_s;
         timeout_r   <= timeout_next_s;
         cpu_reset_r <= cpu_reset_next_s;
         cpu_run_r   <= cpu_run_next_s;
         busy_r      <= busy_next_s;
         host_gnt_r  <= host_gnt_next_s;
      end
   end

   assign bus.cpu_reset = cpu_reset_r;
   assign bus.cpu_run   = cpu_run_r;
   assign bus.host_gnt  = host_gnt_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.timeout   = timeout_r;
   assign bus.cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with RST_CYC=2 and MAX_CYC=8.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   run_ctrl_if #(.CW(16)) bus ();

   run_ctrl #(.CW(16), .RST_CYC(2), .MAX_CYC(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic e_rst, input logic e_run,
                         input logic e_gnt, input logic e_busy, input logic e_done,
                         input logic e_to, input logic [15:0] e_cnt);
      chk({tag, ".cpu_reset"}, {31'd0, bus.cpu_reset}, {31'd0, e_rst});
      chk({tag, ".cpu_run"},   {31'd0, bus.cpu_run},   {31'd0, e_run});
      chk({tag, ".host_gnt"},  {31'd0, bus.host_gnt},  {31'd0, e_gnt});
      chk({tag, ".busy"},      {31'd0, bus.busy},      {31'd0, e_busy});
      chk({tag, ".done"},      {31'd0, bus.done},      {31'd0, e_done});
      chk({tag, ".timeout"},   {31'd0, bus.timeout},   {31'd0, e_to});
      chk({tag, ".cycle_cnt"}, {16'd0, bus.cycle_cnt}, {16'd0, e_cnt});
   endtask

   initial begin
      reset        = 1'b1;
      bus.req      = 1'b0;
      bus.halt     = 1'b0;
      bus.host_req = 1'b0;
      #2;
      chk_st("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      tick(2);
      reset = 1'b0;
      tick(1);
      chk_st("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // 1: halt on the 5th RUN cycle
      bus.req = 1'b1;
      tick(1);
      chk_st("t1_rst_a", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick(1);
      chk_st("t1_rst_b", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick(1);
      chk_st("t1_run1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick(4);
      chk_st("t1_run5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
      bus.halt = 1'b1;
      tick(1);
      chk_st("t1_fin", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
      bus.halt = 1'b0;
      bus.req  = 1'b0;
      tick(1);
      chk_st("t1_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);

      // 2: budget timeout, req dropped mid-run
      bus.req = 1'b1;
      tick(3);
      bus.req = 1'b0;
      tick(7);
      chk_st("t2_run8", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
      tick(1);
      chk_st("t2_fin", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd8);
      tick(1);
      chk_st("t2_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);

      // 3: halt and budget on the same edge
      bus.req = 1'b1;
      tick(1);
      chk_st("t3_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick(2);
      tick(7);
      bus.halt = 1'b1;
      tick(1);
      chk_st("t3_fin", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8);
      bus.halt = 1'b0;
      bus.req  = 1'b0;
      tick(1);

      // 4: host_req wins over req in IDLE
      bus.host_req = 1'b1;
      bus.req      = 1'b1;
      tick(1);
      chk_st("t4_host", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8);
      tick(1);
      chk_st("t4_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8);
      bus.host_req = 1'b0;
      tick(1);
      chk_st("t4_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
      tick(1);
      chk_st("t4_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick(2);
      chk_st("t4_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

      // 5: host blocked during RUN, granted in FIN
      bus.host_req = 1'b1;
      tick(1);
      chk_st("t5_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
      bus.halt = 1'b1;
      tick(1);
      chk_st("t5_fin", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
      bus.halt = 1'b0;
      tick(1);
      chk_st("t5_gnt", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
      bus.req      = 1'b0;
      bus.host_req = 1'b0;
      tick(1);
      chk_st("t5_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

      // 6: async reset in the 3rd RUN cycle
      bus.req = 1'b1;
      tick(3);
      tick(2);
      chk_st("t6_run3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
      #2;
      reset = 1'b1;
      #1;
      chk_st("t6_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      bus.req = 1'b0;
      tick(1);
      chk_st("t6_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
